// File: rtl/pipeline_flow_pkg.sv
// Shared encodings and helpers for the SPARC pipeline flow controller.
package pipeline_flow_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } flow_state_e;

  localparam logic [4:0] REG_G0      = 5'd0;
  localparam logic [3:0] COND_ALWAYS = 4'b1000;

  function automatic logic src_match(input logic used, input logic [4:0] rs, input logic [4:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_detect.sv
// Combinational hazard and annul terms for the instruction sitting in ID.
module pipeline_hazard_detect
  import pipeline_flow_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       id_branch,
  input  logic       id_annul,
  input  logic       id_cond_always,
  input  logic       branch_taken,
  input  logic       ex_load,
  input  logic [4:0] ex_rd,
  input  logic       ex_cc_en,
  output logic       lu_haz,
  output logic       cc_haz,
  output logic       annul
);

  // %g0 never carries a dependency, so loads into it cannot create a hazard
  assign lu_haz = ex_load && (ex_rd != REG_G0) &&
                  (src_match(id_rs1_used, id_rs1, ex_rd) || src_match(id_rs2_used, id_rs2, ex_rd));
  assign cc_haz = id_branch && ex_cc_en;
  assign annul  = id_branch && id_annul && (!branch_taken || id_cond_always);

endmodule

// File: rtl/pipeline_flow_controller.sv
// Flow-control FSM for the five-stage pipeline: PC/nPC/IF_ID strobes, bubbles,
// delay-slot annul, halt drain and a saturating stall counter.
module pipeline_flow_controller
  import pipeline_flow_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES      = 3,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_branch,
  input  logic             id_annul,
  input  logic             id_cond_always,
  input  logic             branch_taken,
  input  logic             ex_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_cc_en,
  input  logic             halt_req,
  output logic             pc_le,
  output logic             npc_le,
  output logic             if_id_le,
  output logic             if_id_flush,
  output logic             cu_nop_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       state
);

  flow_state_e      state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             lu_haz_s, cc_haz_s, annul_s;
  logic             freeze_s, flush_s, count_s;

  pipeline_hazard_detect u_hazard (
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_branch      (id_branch),
    .id_annul       (id_annul),
    .id_cond_always (id_cond_always),
    .branch_taken   (branch_taken),
    .ex_load        (ex_load),
    .ex_rd          (ex_rd),
    .ex_cc_en       (ex_cc_en),
    .lu_haz         (lu_haz_s),
    .cc_haz         (cc_haz_s),
    .annul          (annul_s)
  );

  // Next-state, bubble counter and freeze decision
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    freeze_s = 1'b1;
    flush_s  = 1'b0;
    count_s  = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          if (DRAIN_CYCLES <= 1) begin
            state_d = HALTED;
          end else begin
            state_d = DRAIN;
            cnt_d   = 3'(DRAIN_CYCLES - 1);
          end
        end else if (lu_haz_s) begin
          count_s = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = 3'(LOAD_STALL_CYCLES - 1);
          end else begin
            state_d = RUN;
          end
        end else if (cc_haz_s) begin
          count_s = 1'b1;
        end else begin
          freeze_s = 1'b0;
          flush_s  = annul_s;
        end
      end
      STALL: begin
        count_s = 1'b1;
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DRAIN: begin
        if (cnt_q <= 3'd1) begin
          state_d = HALTED;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HALTED: begin
        if (!halt_req) begin
          state_d = RUN;
        end else begin
          state_d = HALTED;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating stall counter next value
  always_comb begin
    if (count_s && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // State, bubble counter and stall counter registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      stall_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Strobes force the reset pattern directly while clr is held low
  always_comb begin
    if (!clr) begin
      pc_le       = 1'b0;
      npc_le      = 1'b0;
      if_id_le    = 1'b0;
      if_id_flush = 1'b1;
      cu_nop_sel  = 1'b1;
    end else begin
      pc_le       = !freeze_s;
      npc_le      = !freeze_s;
      if_id_le    = !freeze_s;
      if_id_flush = flush_s;
      cu_nop_sel  = freeze_s;
    end
  end

  assign halted       = clr && (state_q == HALTED);
  assign stall_cycles = stall_q;
  assign state        = state_q;

endmodule
